register_bank_reader: RTL
=========================

Name: register_bank_reader

Overview:
Bus-side reader for a bank of tri-state memory registers that share one data bus. Each register drives the bus only while its cs is low and floats (high-Z) while its cs is high. This block sequences the per-register select lines (CsN) one register at a time, waits a settle interval, and captures the bus value. It then presents each word on a valid/ready stream to downstream logic, for example the feature/weight loader of the recognition datapath.

Parameters:
NrOfBits, 8, width of each register and of the shared bus
NrOfRegs, 4, number of registers on the bus (2..16)
SelWidth, 2, index width, ceil(log2(NrOfRegs))
SettleCycles, 1, qualified steps CsN is held low before capture (1..15)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
ClockEnable  in  1  global enable
Tick  in  1  clock-divider tick; step = ClockEnable & Tick
Start  in  1  begin a read burst (sampled on a step in IDLE only)
BaseSel  in  SelWidth  index of the first register to read
Count  in  SelWidth+1  number of registers to read (0..NrOfRegs)
BusData  in  NrOfBits  shared tri-state register bus
CsN  out  NrOfRegs  per-register select, 0 = drive bus, 1 = high-Z
OutData  out  NrOfBits  captured word
OutValid  out  1  OutData valid
OutReady  in  1  downstream accepts the word
OutLast  out  1  high with OutValid on the final word of the burst
Busy  out  1  high in any state other than IDLE
Done  out  1  one-step pulse at burst end

Behaviour:
- All registers update only on rising Clock edges where step=1, except async Reset.
- Reset, async, acts immediately:
  - state=IDLE, CsN=all 1, OutValid=0, OutLast=0, OutData=0, Busy=0, Done=0.
  - Index, remaining count and settle counter all reset to 0.
- FSM states: IDLE, SETTLE, CAPTURE, EMIT, DONE.
- IDLE:
  - Start=1 and Count!=0: latch idx=BaseSel and rem=Count, clear settle counter, go to SETTLE.
  - Start=1 and Count=0: go to DONE with no bus access.
  - BaseSel >= NrOfRegs is wrapped modulo NrOfRegs.
- SETTLE:
  - CsN[idx]=0, all other bits 1.
  - Settle counter increments each step; after SettleCycles steps, go to CAPTURE.
- CAPTURE:
  - CsN[idx] is still 0.
  - On the step: OutData<=BusData, OutValid<=1, OutLast<=(rem==1), go to EMIT.
- EMIT:
  - CsN=all 1. This is the break-before-make gap between registers: at most one CsN bit is ever 0, with at least one step of all-1 between different indices.
  - OutData, OutValid and OutLast hold stable until OutReady=1 on a step.
  - On acceptance: OutValid<=0, OutLast<=0, idx<=(idx+1) mod NrOfRegs (wraps from NrOfRegs-1 to 0), rem<=rem-1.
  - After acceptance: if rem was 1 go to DONE, else clear the settle counter and go to SETTLE.
- DONE: Done=1 for one step, CsN=all 1, then IDLE.
- Start outside IDLE is ignored. A new Start may be accepted on the step right after DONE.
- CsN and Busy are decoded combinationally from registered state/idx only. They never depend on Start or OutReady combinationally.
- Latency (step every cycle, SettleCycles=1):
  - Start at edge t.
  - CsN low during cycles t+1 and t+2.
  - OutValid high from t+3.
  - Each further word takes SettleCycles+2 steps plus the OutReady stall.
- Stall when step=0: nothing changes, including the settle counter and the handshake.
- Reset mid-burst: CsN goes all-1 asynchronously (the bus is released immediately) and any pending word is discarded.
- A floating BusData value is captured as-is; reader correctness requires exactly one selected driver.

Decomposition:
- Shared package: FSM state encodings (3-bit localparams IDLE=0, SETTLE=1, CAPTURE=2, EMIT=3, DONE=4) and the all-ones CsN idle constant.
- One sub-module: cs_onehot_decoder (idx, enable -> active-low one-hot CsN). It is reusable by other bus masters in the memory subsystem.

Test Plan:
- Single read: NrOfRegs=4, reg2 holds 8'hA5, BaseSel=2, Count=1, OutReady=1, Tick=1 -> CsN=4'b1011 for 2 cycles, OutData=A5 with OutValid=OutLast=1 at t+3, Done pulse at t+4.
- Wrap burst: regs {0:11,1:22,2:33,3:44}, BaseSel=3, Count=3 -> words 44,22? no: 44,11,22 in order. OutLast only on 22. CsN never has two 0 bits and is all-1 between words.
- Backpressure: OutReady=0 for 5 cycles after the first OutValid -> OutData/OutValid stable, CsN=all 1, no idx advance; release -> next register is read.
- Tick gating: Tick high every 3rd cycle, ClockEnable=1 -> same word sequence as the single-read case, all transitions only on tick edges, latency 3x.
- Count=0 and busy Start: Count=0 -> Done next step with CsN never low; Start pulsed mid-burst -> ignored, burst length unchanged.
- Reset mid-burst: assert Reset while in SETTLE -> CsN=all 1 and OutValid=0 within the same cycle (async); a subsequent Start runs a clean burst.

Source files
------------

// File: rtl/register_bank_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : register_bank_reader_pkg
// Brief    : Shared FSM encodings and bus-select constants for the bank reader
// Revision : 1.0 - initial release
// ============================================================================
package register_bank_reader_pkg;

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_SETTLE  = 3'd1;
  localparam logic [2:0] c_CAPTURE = 3'd2;
  localparam logic [2:0] c_EMIT    = 3'd3;
  localparam logic [2:0] c_DONE    = 3'd4;

  // Wide enough for the largest supported bank; users slice to their size.
  localparam logic [15:0] c_CS_ALL_HIGH = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/register_bank_reader_cs_onehot_decoder.sv
`default_nettype none
// ============================================================================
// Module   : cs_onehot_decoder
// Brief    : Index + enable to active-low one-hot chip-select vector
// Revision : 1.0 - initial release
// ============================================================================
module cs_onehot_decoder
  import register_bank_reader_pkg::*;
#(
  parameter int NR_OF_REGS = 4,
  parameter int SEL_WIDTH  = 2
) (
  input  logic [SEL_WIDTH-1:0]  i_idx,
  input  logic                  i_enable,
  output logic [NR_OF_REGS-1:0] o_cs_n
);

  always_comb begin
    o_cs_n = c_CS_ALL_HIGH[NR_OF_REGS-1:0];
    if (i_enable) begin
      o_cs_n[i_idx] = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/register_bank_reader.sv
`default_nettype none
// ============================================================================
// Module   : register_bank_reader
// Brief    : Sequences per-register selects on a shared bus, captures each
//            word and streams it out on a valid/ready interface
// Revision : 1.0 - initial release
// ============================================================================
module register_bank_reader
  import register_bank_reader_pkg::*;
#(
  parameter int NrOfBits     = 8,
  parameter int NrOfRegs     = 4,
  parameter int SelWidth     = 2,
  parameter int SettleCycles = 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                ClockEnable,
  input  logic                Tick,
  input  logic                Start,
  input  logic [SelWidth-1:0] BaseSel,
  input  logic [SelWidth:0]   Count,
  input  logic [NrOfBits-1:0] BusData,
  output logic [NrOfRegs-1:0] CsN,
  output logic [NrOfBits-1:0] OutData,
  output logic                OutValid,
  input  logic                OutReady,
  output logic                OutLast,
  output logic                Busy,
  output logic                Done
);

  localparam logic [SelWidth-1:0] c_LAST_IDX    = SelWidth'(NrOfRegs - 1);
  localparam logic [SelWidth:0]   c_NREGS       = (SelWidth + 1)'(NrOfRegs);
  localparam logic [SelWidth:0]   c_REM_ONE     = (SelWidth + 1)'(1);
  localparam logic [3:0]          c_SETTLE_LAST = 4'(SettleCycles - 1);

  logic [2:0]          r_state;
  logic [SelWidth-1:0] r_idx;
  logic [SelWidth:0]   r_rem;
  logic [3:0]          r_settle;
  logic [NrOfBits-1:0] r_data;
  logic                r_valid;
  logic                r_last;

  logic                w_step;
  logic [SelWidth:0]   w_base_ext;
  logic [SelWidth-1:0] w_base;
  logic                w_cs_en;

  assign w_step     = ClockEnable & Tick;
  assign w_base_ext = {1'b0, BaseSel};
  // SelWidth is ceil(log2(NrOfRegs)), so one subtraction always suffices.
  assign w_base     = (w_base_ext >= c_NREGS) ? SelWidth'(w_base_ext - c_NREGS) : BaseSel;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state  <= c_IDLE;
      r_idx    <= '0;
      r_rem    <= '0;
      r_settle <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
    end else if (w_step) begin
      case (r_state)
        c_IDLE: begin
          if (Start) begin
            if (Count != '0) begin
              r_idx    <= w_base;
              r_rem    <= Count;
              r_settle <= '0;
              r_state  <= c_SETTLE;
            end else begin
              r_state <= c_DONE;
            end
          end
        end
        c_SETTLE: begin
          r_settle <= r_settle + 4'd1;
          if (r_settle == c_SETTLE_LAST) begin
            r_state <= c_CAPTURE;
          end
        end
        c_CAPTURE: begin
          r_data  <= BusData;
          r_valid <= 1'b1;
          r_last  <= (r_rem == c_REM_ONE);
          r_state <= c_EMIT;
        end
        c_EMIT: begin
          if (OutReady) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_idx   <= (r_idx == c_LAST_IDX) ? '0 : r_idx + SelWidth'(1);
            r_rem   <= r_rem - c_REM_ONE;
            if (r_rem == c_REM_ONE) begin
              r_state <= c_DONE;
            end else begin
              r_settle <= '0;
              r_state  <= c_SETTLE;
            end
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // Selects come only from registered state so the bus is released on reset.
  assign w_cs_en = (r_state == c_SETTLE) || (r_state == c_CAPTURE);

  cs_onehot_decoder #(
    .NR_OF_REGS (NrOfRegs),
    .SEL_WIDTH  (SelWidth)
  ) u_cs_decoder (
    .i_idx    (r_idx),
    .i_enable (w_cs_en),
    .o_cs_n   (CsN)
  );

  assign OutData  = r_data;
  assign OutValid = r_valid;
  assign OutLast  = r_last;
  assign Busy     = (r_state != c_IDLE);
  assign Done     = (r_state == c_DONE);

endmodule
`default_nettype wire
